// File: rtl/boid_frame_writer.sv
// Snapshots the live boid position table on each accepted frame_end, then
// clears the display buffer and plots one pixel per on-screen boid.
//
// state | meaning
// IDLE  | waiting for frame_end
// CLEAR | one cycle, disp_clear asserted
// DRAW  | one snapshot slot per cycle
// DONE  | one cycle, then back to IDLE
module boid_frame_writer #(
   parameter int MAX_BOIDS      = 4,
   parameter int BITS_FOR_BOIDS = $clog2(MAX_BOIDS),
   parameter int VIDEO_WIDTH    = 640,
   parameter int VIDEO_HEIGHT   = 480,
   parameter int ADDR_WIDTH     = 19
) (
   input  logic                      clock,
   input  logic                      CPU_RESETN,
   input  logic                      cpu_we,
   input  logic [BITS_FOR_BOIDS-1:0] cpu_boid_sel,
   input  logic [9:0]                cpu_x,
   input  logic [8:0]                cpu_y,
   input  logic                      frame_end,
   output logic                      disp_clear,
   output logic                      disp_we,
   output logic [ADDR_WIDTH-1:0]     disp_addr,
   output logic                      busy,
   output logic [7:0]                dropped_cnt,
   output logic [7:0]                overrun_cnt
);

   typedef enum logic [1:0] {IDLE, CLEAR, DRAW, DONE} state_t;

   localparam logic [BITS_FOR_BOIDS-1:0] LAST_SLOT = BITS_FOR_BOIDS'(MAX_BOIDS - 1);
   localparam logic [ADDR_WIDTH-1:0]     VW_A      = ADDR_WIDTH'(VIDEO_WIDTH);

   state_t                    state, state_nxt;
   logic [BITS_FOR_BOIDS-1:0] slot, slot_nxt;
   logic                      accept;
   logic                      draw_go;
   logic [BITS_FOR_BOIDS-1:0] draw_idx;
   logic                      overrun_hit;

   logic [9:0] live_x [MAX_BOIDS];
   logic [8:0] live_y [MAX_BOIDS];
   logic [9:0] snap_x [MAX_BOIDS];
   logic [8:0] snap_y [MAX_BOIDS];

   logic [9:0]            sel_x;
   logic [8:0]            sel_y;
   logic                  in_range;
   logic [ADDR_WIDTH-1:0] pix_addr;

   always_ff @(posedge clock or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         state <= IDLE;
         slot  <= '0;
      end else begin
         state <= state_nxt;
         slot  <= slot_nxt;
      end
   end

   // Registered outputs are loaded one edge early, so draw_idx names the slot
   // that will be on the bus during the coming cycle.
   always_comb begin
      state_nxt = state;
      slot_nxt  = slot;
      accept    = 1'b0;
      draw_go   = 1'b0;
      draw_idx  = '0;
      case (state)
         IDLE: begin
            if (frame_end) begin
               accept    = 1'b1;
               state_nxt = CLEAR;
               slot_nxt  = '0;
            end
         end
         CLEAR: begin
            state_nxt = DRAW;
            slot_nxt  = '0;
            draw_go   = 1'b1;
            draw_idx  = '0;
         end
         DRAW: begin
            if (slot == LAST_SLOT) begin
               state_nxt = DONE;
            end else begin
               slot_nxt = slot + BITS_FOR_BOIDS'(1);
               draw_go  = 1'b1;
               draw_idx = slot + BITS_FOR_BOIDS'(1);
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign overrun_hit = frame_end && (state != IDLE);
   assign busy        = (state != IDLE);

   assign sel_x    = snap_x[draw_idx];
   assign sel_y    = snap_y[draw_idx];
   assign in_range = (32'(sel_x) < VIDEO_WIDTH) && (32'(sel_y) < VIDEO_HEIGHT);
   assign pix_addr = ADDR_WIDTH'(sel_x) + ADDR_WIDTH'(sel_y) * VW_A;

   always_ff @(posedge clock or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         for (int i = 0; i < MAX_BOIDS; i++) begin
            live_x[i] <= '0;
            live_y[i] <= '0;
         end
      end else if (cpu_we) begin
         live_x[cpu_boid_sel] <= cpu_x;
         live_y[cpu_boid_sel] <= cpu_y;
      end
   end

   // Copy happens with nonblocking semantics, so a same-edge cpu_we lands only in live.
   always_ff @(posedge clock or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         for (int i = 0; i < MAX_BOIDS; i++) begin
            snap_x[i] <= '0;
            snap_y[i] <= '0;
         end
      end else if (accept) begin
         snap_x <= live_x;
         snap_y <= live_y;
      end
   end

   always_ff @(posedge clock or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         disp_clear  <= 1'b0;
         disp_we     <= 1'b0;
         disp_addr   <= '0;
         dropped_cnt <= '0;
         overrun_cnt <= '0;
      end else begin
         disp_clear <= accept;
         disp_we    <= draw_go && in_range;
         if (draw_go && in_range) begin
            disp_addr <= pix_addr;
         end
         if (draw_go && !in_range && (dropped_cnt != 8'hFF)) begin
            dropped_cnt <= dropped_cnt + 8'd1;
         end
         if (overrun_hit && (overrun_cnt != 8'hFF)) begin
            overrun_cnt <= overrun_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_boid_frame_writer.sv
// Directed bench for boid_frame_writer: expected pixel addresses are queued
// by the stimulus and a negedge monitor pops them as disp_we appears.
module tb_boid_frame_writer;

   logic        clock = 1'b0;
   logic        CPU_RESETN;
   logic        cpu_we;
   logic [1:0]  cpu_boid_sel;
   logic [9:0]  cpu_x;
   logic [8:0]  cpu_y;
   logic        frame_end;
   logic        disp_clear;
   logic        disp_we;
   logic [18:0] disp_addr;
   logic        busy;
   logic [7:0]  dropped_cnt;
   logic [7:0]  overrun_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int n_clear = 0;
   int n_write = 0;
   logic [18:0] exp_q[$];

   boid_frame_writer dut (
      .clock        (clock),
      .CPU_RESETN   (CPU_RESETN),
      .cpu_we       (cpu_we),
      .cpu_boid_sel (cpu_boid_sel),
      .cpu_x        (cpu_x),
      .cpu_y        (cpu_y),
      .frame_end    (frame_end),
      .disp_clear   (disp_clear),
      .disp_we      (disp_we),
      .disp_addr    (disp_addr),
      .busy         (busy),
      .dropped_cnt  (dropped_cnt),
      .overrun_cnt  (overrun_cnt)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clock) begin
      if (disp_clear) begin
         n_clear++;
         check("clear_we_exclusive", {31'd0, disp_we}, 32'd0);
      end
      if (disp_we) begin
         n_write++;
         if (exp_q.size() == 0) begin
            check("unexpected_write", {13'd0, disp_addr}, 32'hFFFF_FFFF);
         end else begin
            check("write_addr", {13'd0, disp_addr}, {13'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic write_slot(input logic [1:0] sel, input logic [9:0] x, input logic [8:0] y);
      cpu_we = 1'b1; cpu_boid_sel = sel; cpu_x = x; cpu_y = y;
      tick();
      cpu_we = 1'b0;
   endtask

   task automatic pulse_frame();
      frame_end = 1'b1;
      tick();
      frame_end = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int i;
      for (i = 0; i < 200 && busy; i++) @(negedge clock);
      check(name, {31'd0, busy}, 32'd0);
      #1;
   endtask

   task automatic push4(input logic [18:0] a, input logic [18:0] b, input logic [18:0] c, input logic [18:0] d);
      exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back(c); exp_q.push_back(d);
   endtask

   int w0, c0;

   initial begin
      CPU_RESETN = 1'b0; cpu_we = 1'b0; cpu_boid_sel = '0; cpu_x = '0; cpu_y = '0; frame_end = 1'b0;
      #1;
      check("reset_outputs", {dropped_cnt, overrun_cnt, 13'd0, disp_clear, disp_we, busy}, 32'd0);
      check("reset_addr", {13'd0, disp_addr}, 32'd0);
      repeat (3) @(posedge clock);
      #1 CPU_RESETN = 1'b1;
      tick();

      // basic frame with exact timing
      write_slot(2'd0, 10'd0,   9'd0);
      write_slot(2'd1, 10'd639, 9'd479);
      write_slot(2'd2, 10'd10,  9'd1);
      write_slot(2'd3, 10'd320, 9'd240);
      push4(19'd0, 19'd307199, 19'd650, 19'd153920);
      w0 = n_write;
      pulse_frame();
      @(negedge clock);
      check("t1_clear_n1", {30'd0, disp_clear, busy}, 32'd3);
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         check("t1_we_slot", {30'd0, disp_we, busy}, 32'd3);
      end
      @(negedge clock);
      check("t1_done_busy", {30'd0, disp_we, busy}, 32'd1);
      @(negedge clock);
      check("t1_busy_fall", {31'd0, busy}, 32'd0);
      #1;
      check("t1_writes", n_write - w0, 32'd4);
      check("t1_addr_hold", {13'd0, disp_addr}, 32'd153920);

      // off-screen slot 2 is skipped
      write_slot(2'd2, 10'd640, 9'd5);
      exp_q.push_back(19'd0); exp_q.push_back(19'd307199); exp_q.push_back(19'd153920);
      w0 = n_write;
      pulse_frame();
      wait_idle("t2_timeout");
      check("t2_writes", n_write - w0, 32'd3);
      check("t2_dropped", {24'd0, dropped_cnt}, 32'd1);

      // same-edge cpu_we and frame_end: snapshot keeps the old value
      write_slot(2'd1, 10'd5, 9'd5);
      write_slot(2'd2, 10'd10, 9'd1);
      push4(19'd0, 19'd3205, 19'd650, 19'd153920);
      cpu_we = 1'b1; cpu_boid_sel = 2'd1; cpu_x = 10'd100; cpu_y = 9'd100; frame_end = 1'b1;
      tick();
      cpu_we = 1'b0; frame_end = 1'b0;
      wait_idle("t3a_timeout");
      check("t3a_queue", exp_q.size(), 32'd0);
      push4(19'd0, 19'd64100, 19'd650, 19'd153920);
      pulse_frame();
      wait_idle("t3b_timeout");
      check("t3b_queue", exp_q.size(), 32'd0);

      // second frame_end while busy is ignored
      push4(19'd0, 19'd64100, 19'd650, 19'd153920);
      w0 = n_write; c0 = n_clear;
      frame_end = 1'b1; tick(); frame_end = 1'b0; tick(); frame_end = 1'b1; tick(); frame_end = 1'b0;
      wait_idle("t4_timeout");
      tick(); tick();
      check("t4_overrun", {24'd0, overrun_cnt}, 32'd1);
      check("t4_clears", n_clear - c0, 32'd1);
      check("t4_writes", n_write - w0, 32'd4);

      // reset during slot-1 DRAW
      exp_q.push_back(19'd0); exp_q.push_back(19'd64100);
      w0 = n_write;
      pulse_frame();
      @(posedge clock);
      @(posedge clock);
      #7;
      CPU_RESETN = 1'b0;
      #1;
      check("t5_reset_outs", {dropped_cnt, overrun_cnt, 13'd0, disp_clear, disp_we, busy}, 32'd0);
      check("t5_reset_addr", {13'd0, disp_addr}, 32'd0);
      repeat (2) @(posedge clock);
      #1 CPU_RESETN = 1'b1;
      repeat (4) tick();
      check("t5_no_more_writes", n_write - w0, 32'd2);
      check("t5_idle", {31'd0, busy}, 32'd0);
      push4(19'd0, 19'd0, 19'd0, 19'd0);
      w0 = n_write;
      pulse_frame();
      wait_idle("t5b_timeout");
      check("t5_cleared_tables", n_write - w0, 32'd4);

      // saturation of both counters
      for (int s = 0; s < 4; s++) write_slot(s[1:0], 10'd700, 9'd500);
      w0 = n_write;
      frame_end = 1'b1;
      repeat (600) tick();
      frame_end = 1'b0;
      wait_idle("t6_timeout");
      check("t6_overrun_sat", {24'd0, overrun_cnt}, 32'd255);
      check("t6_dropped_sat", {24'd0, dropped_cnt}, 32'd255);
      check("t6_no_writes", n_write - w0, 32'd0);

      check("final_queue_empty", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
